dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (core + DMA) arbiter in front of a single-ported data memory.
// Sub-word stores are done as read-modify-write so the memory only ever sees full-word writes.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [2:0]  c_funct3,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic        c_err,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    localparam int              CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    logic [0:0]    state;
    logic [CW-1:0] starve_cnt;

    logic [31:0]   cap_word;
    logic [29:0]   cap_addr;
    logic [1:0]    cap_off;
    logic          cap_half;
    logic [15:0]   cap_data;
    logic          cap_port;

    logic          resp_c;
    logic          resp_d;
    logic          resp_err;
    logic [31:0]   resp_rdata;

    logic          grant_c;
    logic          grant_d;
    logic          any_gnt;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [2:0]    sel_funct3;
    logic          misaligned;
    logic          sub_store;
    logic [31:0]   merged;

    // Grants are gated by rst_n so every output is quiet while reset is held.
    assign grant_c = rst_n && (state == IDLE) && c_req && (!d_req || (starve_cnt < LIMIT));
    assign grant_d = rst_n && (state == IDLE) && d_req && !grant_c;
    assign any_gnt = grant_c || grant_d;

    assign sel_we     = grant_d ? d_we     : c_we;
    assign sel_addr   = grant_d ? d_addr   : c_addr;
    assign sel_wdata  = grant_d ? d_wdata  : c_wdata;
    assign sel_funct3 = grant_d ? d_funct3 : c_funct3;

    assign sub_store = sel_we && (sel_funct3[1:0] != 2'b10);

    always_comb begin
        misaligned = 1'b1;
        case (sel_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = sel_addr[0];
            3'b010:         misaligned = |sel_addr[1:0];
            default:        misaligned = 1'b1;
        endcase
    end

    always_comb begin
        merged = cap_word;
        if (cap_half) begin
            merged[{cap_off[1], 4'b0000} +: 16] = cap_data;
        end else begin
            merged[{cap_off, 3'b000} +: 8] = cap_data[7:0];
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        if (rst_n && (state == RMW_WR)) begin
            mem_write  = 1'b1;
            mem_addr   = {cap_addr, 2'b00};
            mem_wdata  = merged;
            mem_funct3 = 3'b010;
        end else if (any_gnt && !misaligned) begin
            if (!sel_we) begin
                mem_read   = 1'b1;
                mem_addr   = sel_addr;
                mem_funct3 = sel_funct3;
            end else if (sub_store) begin
                mem_read   = 1'b1;
                mem_addr   = {sel_addr[31:2], 2'b00};
                mem_funct3 = 3'b010;
            end else begin
                mem_write  = 1'b1;
                mem_addr   = sel_addr;
                mem_wdata  = sel_wdata;
                mem_funct3 = sel_funct3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_word   <= '0;
            cap_addr   <= '0;
            cap_off    <= '0;
            cap_half   <= 1'b0;
            cap_data   <= '0;
            cap_port   <= 1'b0;
            resp_c     <= 1'b0;
            resp_d     <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_c     <= 1'b0;
            resp_d     <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (state == RMW_WR) begin
                state  <= IDLE;
                resp_c <= !cap_port;
                resp_d <= cap_port;
            end else if (any_gnt) begin
                if (misaligned) begin
                    resp_c   <= grant_c;
                    resp_d   <= grant_d;
                    resp_err <= 1'b1;
                end else if (sub_store) begin
                    state    <= RMW_WR;
                    cap_word <= mem_rdata;
                    cap_addr <= sel_addr[31:2];
                    cap_off  <= sel_addr[1:0];
                    cap_half <= sel_funct3[0];
                    cap_data <= sel_wdata[15:0];
                    cap_port <= grant_d;
                end else begin
                    resp_c     <= grant_c;
                    resp_d     <= grant_d;
                    resp_rdata <= sel_we ? 32'h0 : mem_rdata;
                end
            end
        end
    end

    // Counts core wins while DMA is kept waiting; DMA takes over once it saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!d_req || grant_d) begin
            starve_cnt <= '0;
        end else if (grant_c && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign c_gnt    = grant_c;
    assign d_gnt    = grant_d;
    assign c_rvalid = resp_c;
    assign d_rvalid = resp_d;
    assign c_err    = resp_c && resp_err;
    assign d_err    = resp_d && resp_err;
    assign c_rdata  = resp_c ? resp_rdata : 32'h0;
    assign d_rdata  = resp_d ? resp_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural data memory, vector table,
// scoreboard of expected responses, and hand-written starvation/reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [2:0]  c_funct3, d_funct3;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    logic        load_mem;
    logic [31:0] mem [0:63];
    logic [31:0] mw;
    logic [7:0]  mb;
    logic [15:0] mh;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        logic [31:0] exp_mwdata;
    } vec_t;
    vec_t vecs[21];

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_funct3   (c_funct3),
        .c_gnt      (c_gnt),
        .c_rvalid   (c_rvalid),
        .c_err      (c_err),
        .c_rdata    (c_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_funct3   (d_funct3),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_err      (d_err),
        .d_rdata    (d_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-organised memory; loads are extended here according to mem_funct3.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'hDEADBEEF;
            mem[8]  <= 32'h11223344;
            mem[12] <= 32'h80FF7F01;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    always_comb begin
        mw = mem[mem_addr[7:2]];
        mb = mw[{mem_addr[1:0], 3'b000} +: 8];
        mh = mw[{mem_addr[1], 4'b0000} +: 16];
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{mb[7]}}, mb};
            3'b001:  mem_rdata = {{16{mh[15]}}, mh};
            3'b100:  mem_rdata = {24'h0, mb};
            3'b101:  mem_rdata = {16'h0, mh};
            default: mem_rdata = mw;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_ctl"}, {22'h0, c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err,
                                    mem_read, mem_write, mem_funct3}, 32'h0);
        checkOutput({tag, "_crd"}, c_rdata, 32'h0);
        checkOutput({tag, "_drd"}, d_rdata, 32'h0);
        checkOutput({tag, "_madr"}, mem_addr, 32'h0);
        checkOutput({tag, "_mwd"}, mem_wdata, 32'h0);
    endtask

    // Response monitor: pops the scoreboard whenever either port reports rvalid.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("exclusive", {29'h0, c_gnt & d_gnt, mem_read & mem_write, c_rvalid & d_rvalid}, 32'h0);
        end
        if (c_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", {31'h0, d_rvalid}, {31'h0, !c_rvalid});
                n_fail++;
                $display("[TB] FAIL rsp_extra: got rvalid with empty scoreboard (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_port", {31'h0, d_rvalid}, {31'h0, e.port});
                checkOutput("rsp_cycle", cyc, e.due);
                checkOutput("rsp_err", {31'h0, d_rvalid ? d_err : c_err}, {31'h0, e.err});
                checkOutput("rsp_rdata", d_rvalid ? d_rdata : c_rdata, e.rdata);
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            checkOutput("rsp_timeout", cyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    task automatic applyStimulus(input logic port, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int lat, input logic [31:0] exp_mwdata);
        int   waited;
        logic granted;
        waited  = 0;
        granted = 1'b0;
        if (!port) begin
            c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
        end else begin
            d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end
        while (!granted && waited < 8) begin
            @(negedge clk);
            if ((port ? d_gnt : c_gnt) === 1'b1) granted = 1'b1;
            else waited++;
        end
        checkOutput("gnt_wait", waited, 0);
        if (granted) begin
            sb.push_back('{port, exp_err, exp_rdata, cyc + lat});
            checkOutput("gnt_other", {31'h0, port ? c_gnt : d_gnt}, 32'h0);
            if (exp_err) begin
                checkOutput("err_nomem", {30'h0, mem_read, mem_write}, 32'h0);
            end else if (!we) begin
                checkOutput("ld_rd", {30'h0, mem_read, mem_write}, 32'h2);
                checkOutput("ld_addr", mem_addr, addr);
                checkOutput("ld_f3", {29'h0, mem_funct3}, {29'h0, f3});
            end else if (lat == 1) begin
                checkOutput("sw_wr", {30'h0, mem_read, mem_write}, 32'h1);
                checkOutput("sw_addr", mem_addr, addr);
                checkOutput("sw_data", mem_wdata, exp_mwdata);
            end else begin
                checkOutput("rmw_rd", {30'h0, mem_read, mem_write}, 32'h2);
                checkOutput("rmw_raddr", mem_addr, {addr[31:2], 2'b00});
                checkOutput("rmw_rf3", {29'h0, mem_funct3}, 32'h2);
            end
        end
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
        if (granted && lat == 2) begin
            @(negedge clk);
            checkOutput("rmw_wr", {30'h0, mem_read, mem_write}, 32'h1);
            checkOutput("rmw_waddr", mem_addr, {addr[31:2], 2'b00});
            checkOutput("rmw_wdata", mem_wdata, exp_mwdata);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic exp_c;
        int   pc;

        vecs[0]  = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 3'b000, 32'h21, 32'hAA,       32'h0,        1'b0, 2, 32'h1122AA44};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h13, 32'h5555,     32'h0,        1'b1, 1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 3'b100, 32'h31, 32'h0,        32'h0000007F, 1'b0, 1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h32, 32'h0,        32'hFFFF80FF, 1'b0, 1, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 3'b101, 32'h32, 32'h0,        32'h000080FF, 1'b0, 1, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 3'b010, 32'h32, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 3'b001, 32'h31, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 3'b011, 32'h30, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b110, 32'h30, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b111, 32'h30, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0, 1, 32'hCAFEF00D};
        vecs[13] = '{1'b0, 1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0, 1, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 3'b001, 32'h42, 32'hFFFF1234, 32'h0,        1'b0, 2, 32'h1234F00D};
        vecs[15] = '{1'b0, 1'b1, 3'b000, 32'h40, 32'hFFFFFF55, 32'h0,        1'b0, 2, 32'h1234F055};
        vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        32'h1234F055, 1'b0, 1, 32'h0};
        vecs[17] = '{1'b0, 1'b1, 3'b010, 32'h41, 32'h77777777, 32'h0,        1'b1, 1, 32'h0};
        vecs[18] = '{1'b1, 1'b1, 3'b000, 32'h43, 32'h00000099, 32'h0,        1'b0, 2, 32'h9934F055};
        vecs[19] = '{1'b0, 1'b0, 3'b010, 32'h40, 32'h0,        32'h9934F055, 1'b0, 1, 32'h0};
        vecs[20] = '{1'b0, 1'b0, 3'b101, 32'h42, 32'h0,        32'h00009934, 1'b0, 1, 32'h0};

        rst_n    = 1'b0;
        load_mem = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_funct3 = 3'b000;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_funct3 = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;
        // Requests presented during reset must not be granted.
        c_req = 1'b1; c_funct3 = 3'b010; c_addr = 32'h10;
        d_req = 1'b1; d_funct3 = 3'b010; d_addr = 32'h20;
        @(negedge clk);
        checkQuiet("reset");
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].lat, vecs[i].exp_mwdata);
        end

        @(negedge clk);
        checkOutput("idle_mem", {27'h0, mem_read, mem_write, mem_funct3}, 32'h0);
        checkOutput("idle_addr", mem_addr | mem_wdata, 32'h0);
        @(posedge clk); #1;

        // Both ports loading continuously: four core grants, then one DMA grant.
        c_we = 1'b0; c_funct3 = 3'b010; c_addr = 32'h10; c_req = 1'b1;
        d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h30; d_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            exp_c = ((i % 5) != 4);
            checkOutput("starve_c", {31'h0, c_gnt}, {31'h0, exp_c});
            checkOutput("starve_d", {31'h0, d_gnt}, {31'h0, !exp_c});
            if (c_gnt) sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF, cyc + 1});
            if (d_gnt) sb.push_back('{1'b1, 1'b0, 32'h80FF7F01, cyc + 1});
        end
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;

        // Core byte stores against DMA loads: no grant in any RMW write cycle.
        c_we = 1'b1; c_funct3 = 3'b000; c_addr = 32'h51; c_wdata = 32'h5A; c_req = 1'b1;
        d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h30; d_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            pc = i % 9;
            checkOutput("rmw_starve_c", {31'h0, c_gnt}, {31'h0, (pc % 2 == 0) && (pc != 8)});
            checkOutput("rmw_starve_d", {31'h0, d_gnt}, {31'h0, pc == 8});
            if (c_gnt) sb.push_back('{1'b0, 1'b0, 32'h0, cyc + 2});
            if (d_gnt) sb.push_back('{1'b1, 1'b0, 32'h80FF7F01, cyc + 1});
        end
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during the RMW write cycle aborts the store.
        c_we = 1'b1; c_funct3 = 3'b001; c_addr = 32'h54; c_wdata = 32'hBEEF; c_req = 1'b1;
        @(negedge clk);
        checkOutput("abort_gnt", {31'h0, c_gnt}, 32'h1);
        @(posedge clk); #1;
        c_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkQuiet("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h54, 32'h0, 32'h0, 1'b0, 1, 32'h0);

        // Core store immediately followed by DMA load of the same word.
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h60, 32'h0BADC0DE, 32'h0, 1'b0, 1, 32'h0BADC0DE);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h60, 32'h0, 32'h0BADC0DE, 1'b0, 1, 32'h0);

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("mem_sb21", mem[8], 32'h1122AA44);
        checkOutput("mem_w40", mem[16], 32'h9934F055);
        checkOutput("mem_sb51", mem[20], 32'h00005A00);
        checkOutput("mem_abort54", mem[21], 32'h0);
        checkOutput("mem_sw60", mem[24], 32'h0BADC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
